dm_arb: RTL and testbench
=========================

DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameter: CPU_PRIO_MAX, default 4, max consecutive port-0 grants while port 1 waits (range 1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 p0_req, p1_req  input  1 each  access request; port 0 = CPU MEM stage, port 1 = DMA/debug.
REQ-005 p0_we, p1_we  input  1 each  1 = store, 0 = load.
REQ-006 p0_addr, p1_addr  input  32 each  byte address.
REQ-007 p0_wdata, p1_wdata  input  32 each  store data.
REQ-008 p0_type, p1_type  input  3 each  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
REQ-009 p0_gnt, p1_gnt  output  1 each  one-cycle pulse: request accepted.
REQ-010 p0_rvalid, p1_rvalid  output  1 each  one-cycle completion pulse (loads and stores).
REQ-011 rdata  output  32  load data; valid only with an rvalid pulse.
REQ-012 err  output  1  misaligned-access flag; valid only with an rvalid pulse.
REQ-013 dm_DMWr, dm_addr[31:0], dm_din[31:0], dm_DMType[2:0]  output  data-memory command.
REQ-014 dm_dout  input  32  combinational data-memory read data.

Function
REQ-015 FSM states IDLE, ACCESS; IDLE->ACCESS when any req is high in IDLE; ACCESS->IDLE unconditionally.
REQ-016 In IDLE with a req: select winner, pulse its gnt, latch we/addr/wdata/type into the command register; the loser's gnt stays 0.
REQ-017 Requesters hold req and command stable until gnt; req is ignored in ACCESS.
REQ-018 Winner: port 0, unless p1_req=1 and streak>=CPU_PRIO_MAX, then port 1.
REQ-019 streak (4-bit, saturating at 15): +1 on a port-0 grant with p1_req=1; cleared on a port-1 grant or any IDLE cycle with p1_req=0.
REQ-020 In ACCESS: dm_addr/dm_din/dm_DMType driven from the command register; dm_DMWr=we for exactly that cycle.
REQ-021 dm_DMWr=0 in every cycle not in ACCESS.
REQ-022 At the end of ACCESS, dm_dout is captured into rdata (loads) or rdata=0 (stores); the owner's rvalid pulses in the next cycle.
REQ-023 Latency: gnt at cycle N, memory access at N+1, rvalid/rdata at N+2; one access per 2 cycles maximum.
REQ-024 rdata and err hold their values until the next completion.
REQ-025 Simultaneous p0_req and p1_req follow REQ-018; never both gnt high.

Reset
REQ-026 rstn=0 forces IDLE, streak=0, command register=0, all gnt/rvalid/err=0, rdata=0, dm_DMWr=0, dm_addr/dm_din/dm_DMType=0, immediately and asynchronously.
REQ-027 Reset during ACCESS aborts the access: no write, no rvalid after release.
REQ-028 After rstn rises, the first grant occurs no earlier than the first clk edge with rstn high.

Configuration
REQ-029 Macro DM_ARB_MISALIGN_CHK_EN defined: word type with addr[1:0]!=0, or half types with addr[0]=1, are misaligned; ACCESS holds dm_DMWr=0, rdata=0, err=1 with rvalid.
REQ-030 Macro not defined: no alignment check; all accesses are forwarded as issued; err tied to 0.

Verification
REQ-031 p0 load word 0x10 (mem=0xDEADBEEF) -> p0_gnt at N, dm_DMWr=0 at N+1, p0_rvalid and rdata=0xDEADBEEF at N+2.
REQ-032 p1 store byte 0xA5 to 0x23 -> dm_DMWr=1 for exactly one cycle, dm_DMType=011, dm_addr=0x23, p1_rvalid two cycles after gnt.
REQ-033 p0 and p1 requesting continuously, CPU_PRIO_MAX=4 -> grant order p0,p0,p0,p0,p1, repeating.
REQ-034 rstn pulsed low during ACCESS of a store -> dm_DMWr drops to 0 immediately; no rvalid; memory unchanged.
REQ-035 With DM_ARB_MISALIGN_CHK_EN: p0 store word to 0x22 -> dm_DMWr=0, err=1, rdata=0 with p0_rvalid; without the macro: write issued, err=0.

Source files
------------

// File: rtl/dm_arb_if.sv
// dm_arb_if: requester, completion and data-memory signals of the dm_arb arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dm_arb_if;
   logic        p0_req,    p1_req;
   logic        p0_we,     p1_we;
   logic [31:0] p0_addr,   p1_addr;
   logic [31:0] p0_wdata,  p1_wdata;
   logic [2:0]  p0_type,   p1_type;
   logic        p0_gnt,    p1_gnt;
   logic        p0_rvalid, p1_rvalid;
   logic [31:0] rdata;
   logic        err;
   logic        dm_DMWr;
   logic [31:0] dm_addr;
   logic [31:0] dm_din;
   logic [2:0]  dm_DMType;
   logic [31:0] dm_dout;

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_wdata, p1_wdata, p0_type, p1_type, dm_dout,
      output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, err,
             dm_DMWr, dm_addr, dm_din, dm_DMType
   );

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_wdata, p1_wdata, p0_type, p1_type, dm_dout,
      input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, err,
             dm_DMWr, dm_addr, dm_din, dm_DMType
   );
endinterface

// File: rtl/dm_arb.sv
// dm_arb: two-port data-memory arbiter, CPU port 0 favoured with a bounded DMA wait.
// Define DM_ARB_MISALIGN_CHK_EN to suppress and flag misaligned word/half accesses.
module dm_arb #(
   parameter int unsigned CPU_PRIO_MAX = 4
) (
   input  logic    clk,
   input  logic    rstn,
   dm_arb_if.slave bus
);
   localparam logic [3:0] PRIO_MAX = 4'(CPU_PRIO_MAX);

   typedef enum logic {IDLE, ACCESS} state_e;

   state_e      state_q, state_d;
   logic        arb_en_q, arb_en_d;
   logic [3:0]  streak_q, streak_d;
   logic        cmd_we_q, cmd_we_d;
   logic [31:0] cmd_addr_q, cmd_addr_d;
   logic [31:0] cmd_wdata_q, cmd_wdata_d;
   logic [2:0]  cmd_type_q, cmd_type_d;
   logic        owner_q, owner_d;
   logic        p0_rvalid_q, p0_rvalid_d;
   logic        p1_rvalid_q, p1_rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        win_p0, win_p1;
   logic        misalign;

`ifdef DM_ARB_MISALIGN_CHK_EN
   always_comb begin
      misalign = 1'b0;
      case (cmd_type_q)
         3'b000:         misalign = (cmd_addr_q[1:0] != 2'b00);
         3'b001, 3'b010: misalign = cmd_addr_q[0];
         default:        misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // Grants are held off until the first clock edge after reset release.
   always_comb begin
      win_p0 = 1'b0;
      win_p1 = 1'b0;
      if (state_q == IDLE && arb_en_q) begin
         if (bus.p1_req && (!bus.p0_req || streak_q >= PRIO_MAX)) win_p1 = 1'b1;
         else if (bus.p0_req)                                     win_p0 = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      arb_en_d    = 1'b1;
      streak_d    = streak_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      cmd_type_d  = cmd_type_q;
      owner_d     = owner_q;
      p0_rvalid_d = 1'b0;
      p1_rvalid_d = 1'b0;
      rdata_d     = rdata_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (!bus.p1_req || win_p1)           streak_d = '0;
            else if (win_p0 && streak_q != 4'hF) streak_d = streak_q + 4'd1;
            if (win_p1) begin
               state_d     = ACCESS;
               owner_d     = 1'b1;
               cmd_we_d    = bus.p1_we;
               cmd_addr_d  = bus.p1_addr;
               cmd_wdata_d = bus.p1_wdata;
               cmd_type_d  = bus.p1_type;
            end else if (win_p0) begin
               state_d     = ACCESS;
               owner_d     = 1'b0;
               cmd_we_d    = bus.p0_we;
               cmd_addr_d  = bus.p0_addr;
               cmd_wdata_d = bus.p0_wdata;
               cmd_type_d  = bus.p0_type;
            end
         end
         ACCESS: begin
            state_d     = IDLE;
            p0_rvalid_d = !owner_q;
            p1_rvalid_d = owner_q;
            rdata_d     = (cmd_we_q || misalign) ? '0 : bus.dm_dout;
            err_d       = misalign;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         arb_en_q    <= 1'b0;
         streak_q    <= '0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_type_q  <= '0;
         owner_q     <= 1'b0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         arb_en_q    <= arb_en_d;
         streak_q    <= streak_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         cmd_type_q  <= cmd_type_d;
         owner_q     <= owner_d;
         p0_rvalid_q <= p0_rvalid_d;
         p1_rvalid_q <= p1_rvalid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign bus.p0_gnt    = win_p0;
   assign bus.p1_gnt    = win_p1;
   assign bus.p0_rvalid = p0_rvalid_q;
   assign bus.p1_rvalid = p1_rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;
   assign bus.dm_DMWr   = (state_q == ACCESS) && cmd_we_q && !misalign;
   assign bus.dm_addr   = cmd_addr_q;
   assign bus.dm_din    = cmd_wdata_q;
   assign bus.dm_DMType = cmd_type_q;
endmodule

// File: tb/tb_dm_arb.sv
// tb_dm_arb: directed and randomized checks of dm_arb against a behavioural model.
// Honours DM_ARB_MISALIGN_CHK_EN when computing expected err/rdata/write behaviour.
module tb_dm_arb;
   localparam int unsigned MAX = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   dm_arb_if bus ();

   dm_arb #(.CPU_PRIO_MAX(MAX)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:63];
   logic        poke_en = 1'b0;
   logic [5:0]  poke_a  = '0;
   logic [31:0] poke_d  = '0;

   always @(posedge clk) begin
      if (bus.dm_DMWr)  mem[bus.dm_addr[7:2]] <= bus.dm_din;
      else if (poke_en) mem[poke_a] <= poke_d;
   end
   assign bus.dm_dout = mem[bus.dm_addr[7:2]];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit mis(input logic [2:0] t, input logic [31:0] a);
`ifdef DM_ARB_MISALIGN_CHK_EN
      return (t == 3'b000 && a[1:0] != 2'b00) || ((t == 3'b001 || t == 3'b010) && a[0]);
`else
      return 1'b0;
`endif
   endfunction

   task automatic poke(input int a, input logic [31:0] d);
      @(posedge clk); #1;
      poke_en = 1'b1; poke_a = 6'(a); poke_d = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic drive(input int p, input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] typ);
      if (p == 0) begin
         bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_type = typ;
      end else begin
         bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_type = typ;
      end
   endtask

   task automatic rand_port(input int p);
      if ($urandom_range(0, 3) != 0)
         drive(p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
               3'($urandom_range(0, 4)));
      else
         drive(p, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // One isolated transaction, checked cycle by cycle from gnt through the completion.
   task automatic txn(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] typ, input string tag);
      bit          m;
      int          w;
      logic [31:0] exp_rd, exp_mem;
      m       = mis(typ, addr);
      w       = int'(addr[7:2]);
      exp_rd  = (we || m) ? '0 : mem[w];
      exp_mem = (we && !m) ? wdata : mem[w];
      @(posedge clk); #1;
      drive(p, 1'b1, we, addr, wdata, typ);
      @(negedge clk);
      check({tag, "_gnt0"}, bus.p0_gnt, 32'(p == 0));
      check({tag, "_gnt1"}, bus.p1_gnt, 32'(p == 1));
      @(posedge clk); #1;
      drive(p, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check({tag, "_acc_wr"},   bus.dm_DMWr,   32'(we && !m));
      check({tag, "_acc_addr"}, bus.dm_addr,   addr);
      check({tag, "_acc_type"}, bus.dm_DMType, 32'(typ));
      check({tag, "_acc_din"},  bus.dm_din,    wdata);
      @(negedge clk);
      check({tag, "_rv0"},   bus.p0_rvalid, 32'(p == 0));
      check({tag, "_rv1"},   bus.p1_rvalid, 32'(p == 1));
      check({tag, "_rdata"}, bus.rdata,     exp_rd);
      check({tag, "_err"},   bus.err,       32'(m));
      check({tag, "_wr_off"}, bus.dm_DMWr,  32'(0));
      @(negedge clk);
      check({tag, "_rv_end"}, 32'(bus.p0_rvalid | bus.p1_rvalid), 32'(0));
      check({tag, "_hold"},   bus.rdata, exp_rd);
      check({tag, "_mem"},    mem[w],    exp_mem);
   endtask

   initial begin
      logic [31:0] ref_mem [0:63];
      int          k;
      int          streak_m, due;
      bit          pend, pport, pwe, pmis, busy, g0_prev, g1_prev, eg0, eg1;
      logic [31:0] pdata, last_rdata, a;
      bit          last_err;

      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      rstn = 1'b0;
      for (int i = 0; i < 64; i++) poke(i, $urandom);
      poke(4, 32'hDEADBEEF);
      poke(8, 32'h11111111);

      // Reset holds every output low even with both requests asserted.
      drive(0, 1'b1, 1'b0, 32'h10, '0, 3'b000);
      drive(1, 1'b1, 1'b1, 32'h40, 32'h55, 3'b000);
      @(negedge clk);
      check("rst_gnt",    32'(bus.p0_gnt | bus.p1_gnt),       32'(0));
      check("rst_rvalid", 32'(bus.p0_rvalid | bus.p1_rvalid), 32'(0));
      check("rst_rdata",  bus.rdata,     32'(0));
      check("rst_err",    bus.err,       32'(0));
      check("rst_wr",     bus.dm_DMWr,   32'(0));
      check("rst_addr",   bus.dm_addr,   32'(0));
      check("rst_din",    bus.dm_din,    32'(0));
      check("rst_type",   bus.dm_DMType, 32'(0));
      drive(1, 1'b0, 1'b0, '0, '0, '0);

      // Release with p0 load word 0x10 pending: no grant before the first edge.
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("rel_gnt_early", bus.p0_gnt, 32'(0));
      @(posedge clk); #1;
      check("ldw_gnt0", bus.p0_gnt, 32'(1));
      check("ldw_gnt1", bus.p1_gnt, 32'(0));
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("ldw_acc_wr",   bus.dm_DMWr, 32'(0));
      check("ldw_acc_addr", bus.dm_addr, 32'h10);
      @(negedge clk);
      check("ldw_rv0",   bus.p0_rvalid, 32'(1));
      check("ldw_rdata", bus.rdata,     32'hDEADBEEF);
      check("ldw_err",   bus.err,       32'(0));

      txn(1, 1'b1, 32'h23, 32'h000000A5, 3'b011, "st_b");
      txn(0, 1'b1, 32'h22, 32'h12345678, 3'b000, "st_w_mis");
      txn(0, 1'b0, 32'h21, 32'h0,        3'b001, "ld_h_mis");
      txn(1, 1'b0, 32'h23, 32'h0,        3'b100, "ld_bu");
      txn(0, 1'b0, 32'h10, 32'h0,        3'b000, "ld_w");

      // Continuous contention: MAX port-0 grants, then one port-1 grant.
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h10, '0, 3'b000);
      drive(1, 1'b1, 1'b0, 32'h20, '0, 3'b000);
      k = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         check("both_gnt", 32'(bus.p0_gnt & bus.p1_gnt), 32'(0));
         if (bus.p0_gnt || bus.p1_gnt) begin
            check("order", bus.p1_gnt, 32'((k % (MAX + 1)) == MAX));
            k++;
         end
      end
      check("n_grants", 32'(k), 32'(15));
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) @(negedge clk);

      // Reset in the ACCESS cycle of a store aborts it.
      poke(12, 32'hCAFEF00D);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, 32'h30, 32'h0BADF00D, 3'b000);
      @(negedge clk);
      check("abort_gnt", bus.p0_gnt, 32'(1));
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("abort_wr_on", bus.dm_DMWr, 32'(1));
      #1 rstn = 1'b0;
      #1;
      check("abort_wr_off", bus.dm_DMWr, 32'(0));
      check("abort_addr",   bus.dm_addr, 32'(0));
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_rv", 32'(bus.p0_rvalid | bus.p1_rvalid), 32'(0));
      end
      check("abort_mem", mem[12], 32'hCAFEF00D);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
      streak_m = 0; pend = 1'b0; due = 0; pport = 1'b0; pwe = 1'b0; pmis = 1'b0; pdata = '0;
      last_rdata = '0; last_err = 1'b0; g0_prev = 1'b0; g1_prev = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (!bus.p0_req || g0_prev) rand_port(0);
         if (!bus.p1_req || g1_prev) rand_port(1);
         @(negedge clk);
         busy = pend && (c == due - 1);
         check("r_wr", bus.dm_DMWr, 32'(busy && pwe && !pmis));
         if (pend && c == due) begin
            check("r_rv0",   bus.p0_rvalid, 32'(!pport));
            check("r_rv1",   bus.p1_rvalid, 32'(pport));
            check("r_rdata", bus.rdata,     pdata);
            check("r_err",   bus.err,       32'(pmis));
            last_rdata = pdata;
            last_err   = pmis;
            pend       = 1'b0;
         end else begin
            check("r_no_rv",  32'(bus.p0_rvalid | bus.p1_rvalid), 32'(0));
            check("r_hold",   bus.rdata, last_rdata);
            check("r_hold_e", bus.err,   32'(last_err));
         end
         eg0 = 1'b0;
         eg1 = 1'b0;
         if (!busy) begin
            if (bus.p1_req && (!bus.p0_req || streak_m >= int'(MAX))) eg1 = 1'b1;
            else if (bus.p0_req)                                      eg0 = 1'b1;
            if (!bus.p1_req || eg1)      streak_m = 0;
            else if (streak_m < 15)      streak_m++;
            if (eg0 || eg1) begin
               pend  = 1'b1;
               due   = c + 2;
               pport = eg1;
               pwe   = eg1 ? bus.p1_we : bus.p0_we;
               a     = eg1 ? bus.p1_addr : bus.p0_addr;
               pmis  = mis(eg1 ? bus.p1_type : bus.p0_type, a);
               pdata = (pwe || pmis) ? '0 : ref_mem[a[7:2]];
               if (pwe && !pmis) ref_mem[a[7:2]] = eg1 ? bus.p1_wdata : bus.p0_wdata;
            end
         end
         check("r_gnt0", bus.p0_gnt, 32'(eg0));
         check("r_gnt1", bus.p1_gnt, 32'(eg1));
         g0_prev = bus.p0_gnt;
         g1_prev = bus.p1_gnt;
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
